izz_dequant_idpcm: RTL

//  Decoder-side counterpart of the encoder's quantize/zig-zag/DPCM stage.
//  - Accepts a serial stream of 64 coefficients per 8x8 block, in zig-zag order.
//  - Reconstructs DC from its DPCM difference.
//  - De-quantizes each coefficient with the QF=50 luma table.
//  - Scatters coefficients into natural (row,col) order.
//  - Presents the full block to the IDCT stage with a one-cycle valid pulse.

---
 rtl/izz_dequant_idpcm_pkg.sv | 49 ++++
 rtl/izz_dequant_idpcm_if.sv | 23 ++
 rtl/izz_dequant_idpcm_sat.sv | 31 +++
 rtl/izz_dequant_idpcm.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/izz_dequant_idpcm_pkg.sv
// Shared constants, types and tables for the zig-zag / dequant / inverse-DPCM
// decoder stage: zig-zag to natural index map and the QF=50 luma table.
package jpeg_pkg;

  localparam int COEF_W = 11;
  localparam int DPCM_W = 12;
  localparam int QW     = 8;
  localparam int IDX_W  = 6;
  localparam int PROD_W = COEF_W + QW;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;

  localparam logic signed [PROD_W-1:0] PROD_MAX = 19'sd1023;
  localparam logic signed [PROD_W-1:0] PROD_MIN = -19'sd1024;
  localparam coef_t COEF_MAX = 11'sh3FF;
  localparam coef_t COEF_MIN = 11'sh400;

  // Zig-zag scan position -> natural row-major index (row*8 + col).
  localparam logic [IDX_W-1:0] ZZ_TO_NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Standard luminance quantization table at quality 50, natural order.
  localparam logic [QW-1:0] Q_LUMA50 [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

endpackage

// File: rtl/izz_dequant_idpcm_if.sv
// Coefficient input stream and reconstructed block output of the decoder stage.
interface izz_dequant_idpcm_if;
  import jpeg_pkg::*;

  logic                     dc_clr;
  logic                     coef_valid;
  logic                     coef_sof;
  logic signed [DPCM_W-1:0] coef_in;
  coef_t                    block_out [8][8];
  logic                     block_valid;
  logic                     seq_err;

  modport slave (
    input  dc_clr, coef_valid, coef_sof, coef_in,
    output block_out, block_valid, seq_err
  );

  modport master (
    output dc_clr, coef_valid, coef_sof, coef_in,
    input  block_out, block_valid, seq_err
  );

endinterface

// File: rtl/izz_dequant_idpcm_sat.sv
// Signed coefficient times unsigned quantizer step, saturated back to the
// 11-bit reconstructed sample range. Purely combinational.
module jpeg_dequant_sat
  import jpeg_pkg::*;
(
  input  coef_t           coef,
  input  logic [QW-1:0]   q,
  output coef_t           deq
);

  logic signed [PROD_W-1:0] coef_x;
  logic signed [PROD_W-1:0] q_x;
  logic signed [PROD_W-1:0] prod;

  assign coef_x = PROD_W'(coef);
  assign q_x    = PROD_W'({1'b0, q});
  assign prod   = coef_x * q_x;

  // Clamp the full-precision product into [-1024, +1023].
  always_comb begin
    deq = prod[COEF_W-1:0];
    if (prod > PROD_MAX) begin
      deq = COEF_MAX;
    end else if (prod < PROD_MIN) begin
      deq = COEF_MIN;
    end else begin
      deq = prod[COEF_W-1:0];
    end
  end

endmodule

// File: rtl/izz_dequant_idpcm.sv
// Decoder stage: framing FSM over a zig-zag coefficient stream, inverse DC
// DPCM, dequantization and scatter to natural order. A completed block is
// published on block_out two cycles after its last coefficient is accepted.
module izz_dequant_idpcm
  import jpeg_pkg::*;
(
  input  logic               clk,
  input  logic               img_rst,
  izz_dequant_idpcm_if.slave bus
);

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  coef_t             dc_prev_r, dc_pend_r;
  coef_t             dc_base_s, dc_sum_s;
  logic              dc_pend_ld_s, dc_commit_s, err_s;

  logic              s1_valid_s, s1_valid_r;
  logic [IDX_W-1:0]  s1_idx_s, s1_idx_r;
  coef_t             s1_coef_s, s1_coef_r;

  logic [IDX_W-1:0]  nat_s;
  logic [QW-1:0]     q_s;
  coef_t             deq_s;
  coef_t             work_buf_r [8][8];

  // A dc_clr coinciding with a DC accept makes that block predict from zero.
  always_comb begin
    dc_base_s = dc_prev_r;
    if (bus.dc_clr) begin
      dc_base_s = '0;
    end else begin
      dc_base_s = dc_prev_r;
    end
    dc_sum_s = dc_base_s + bus.coef_in[COEF_W-1:0];
  end

  // Framing FSM: next state, next index, stage-1 load and error pulse.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    err_s        = 1'b0;
    dc_pend_ld_s = 1'b0;
    dc_commit_s  = 1'b0;
    s1_valid_s   = 1'b0;
    s1_idx_s     = 6'd0;
    s1_coef_s    = bus.coef_in[COEF_W-1:0];
    case (state_r)
      IDLE: begin
        if (bus.coef_valid && bus.coef_sof) begin
          state_s      = COLLECT;
          idx_s        = 6'd1;
          dc_pend_ld_s = 1'b1;
          s1_valid_s   = 1'b1;
          s1_coef_s    = dc_sum_s;
        end else if (bus.coef_valid) begin
          err_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if (bus.coef_valid && bus.coef_sof) begin
          // Abandon the partial block and restart on the new DC.
          err_s        = 1'b1;
          idx_s        = 6'd1;
          dc_pend_ld_s = 1'b1;
          s1_valid_s   = 1'b1;
          s1_coef_s    = dc_sum_s;
        end else if (bus.coef_valid) begin
          s1_valid_s = 1'b1;
          s1_idx_s   = idx_r;
          if (idx_r == LAST_IDX) begin
            state_s     = IDLE;
            idx_s       = 6'd0;
            dc_commit_s = 1'b1;
          end else begin
            idx_s = idx_r + 6'd1;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 6'd0;
      end
    endcase
  end

  // FSM state, scan index and DC predictor registers.
  always_ff @(posedge clk or posedge img_rst) begin
    if (img_rst) begin
      state_r   <= IDLE;
      idx_r     <= 6'd0;
      dc_prev_r <= '0;
      dc_pend_r <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (dc_pend_ld_s) begin
        dc_pend_r <= dc_sum_s;
      end
      // The predictor only advances once its block has fully arrived.
      if (bus.dc_clr) begin
        dc_prev_r <= '0;
      end else if (dc_commit_s) begin
        dc_prev_r <= dc_pend_r;
      end
    end
  end

  // Stage 1 capture and registered framing-error pulse.
  always_ff @(posedge clk or posedge img_rst) begin
    if (img_rst) begin
      s1_valid_r  <= 1'b0;
      s1_idx_r    <= 6'd0;
      s1_coef_r   <= '0;
      bus.seq_err <= 1'b0;
    end else begin
      s1_valid_r  <= s1_valid_s;
      s1_idx_r    <= s1_idx_s;
      s1_coef_r   <= s1_coef_s;
      bus.seq_err <= err_s;
    end
  end

  assign nat_s = ZZ_TO_NAT[s1_idx_r];
  assign q_s   = Q_LUMA50[nat_s];

  jpeg_dequant_sat u_sat (
    .coef (s1_coef_r),
    .q    (q_s),
    .deq  (deq_s)
  );

  // Stage 2: scatter into the work buffer; publish the block after index 63.
  always_ff @(posedge clk or posedge img_rst) begin
    if (img_rst) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          work_buf_r[r][c]    <= '0;
          bus.block_out[r][c] <= '0;
        end
      end
      bus.block_valid <= 1'b0;
    end else begin
      bus.block_valid <= s1_valid_r && (s1_idx_r == LAST_IDX);
      if (s1_valid_r) begin
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            if (nat_s == {3'(r), 3'(c)}) begin
              work_buf_r[r][c] <= deq_s;
            end else if (s1_idx_r == 6'd0) begin
              work_buf_r[r][c] <= '0;
            end
          end
        end
        if (s1_idx_r == LAST_IDX) begin
          for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
              if (nat_s == {3'(r), 3'(c)}) begin
                bus.block_out[r][c] <= deq_s;
              end else begin
                bus.block_out[r][c] <= work_buf_r[r][c];
              end
            end
          end
        end
      end
    end
  end

endmodule
